// File: rtl/opendap_mem_ap_apb_if.sv
// rtl/opendap_mem_ap_apb_if.sv - AP-side and APB-side bus interfaces of the MEM-AP
interface opendap_ap_if;
  logic [7:0]  ap_sel;
  logic [5:0]  ap_addr;
  logic [31:0] ap_wdata;
  logic        ap_wen;
  logic        ap_ren;
  logic        ap_abort;
  logic [31:0] ap_rdata;
  logic        ap_rdy;
  logic        ap_err;

  modport master (
    output ap_sel, ap_addr, ap_wdata, ap_wen, ap_ren, ap_abort,
    input  ap_rdata, ap_rdy, ap_err
  );
  modport slave (
    input  ap_sel, ap_addr, ap_wdata, ap_wen, ap_ren, ap_abort,
    output ap_rdata, ap_rdy, ap_err
  );
endinterface

interface opendap_apb_if;
  logic [31:0] apb_paddr;
  logic        apb_psel;
  logic        apb_penable;
  logic        apb_pwrite;
  logic [31:0] apb_pwdata;
  logic [31:0] apb_prdata;
  logic        apb_pready;
  logic        apb_pslverr;

  modport master (
    output apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
    input  apb_prdata, apb_pready, apb_pslverr
  );
  modport slave (
    input  apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata,
    output apb_prdata, apb_pready, apb_pslverr
  );
endinterface

// File: rtl/opendap_mem_ap_apb.sv
// rtl/opendap_mem_ap_apb.sv - single MEM-AP turning AP register accesses into APB transfers
module opendap_mem_ap_apb #(
  parameter logic [7:0]  APSEL = 8'd0,
  parameter logic [31:0] IDR   = 32'h0477_0002,
  parameter logic [31:0] BASE  = 32'h0000_0003
) (
  input logic           swclk,
  input logic           rst_n,
  opendap_ap_if.slave   ap,
  opendap_apb_if.master apb
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  addr_inc;
  logic [31:0] tar;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        xfer_drw;
  logic [31:0] reg_rdata;

  logic strobe;
  logic sel_hit;
  logic is_drw;
  logic is_bd;
  logic start;
  logic done;

  // A strobe coinciding with abort, or arriving while busy, is dropped.
  assign strobe  = (state == IDLE) && (ap.ap_wen || ap.ap_ren) && !ap.ap_abort;
  assign sel_hit = (ap.ap_sel == APSEL);
  assign is_drw  = (ap.ap_addr == 6'h03);
  assign is_bd   = (ap.ap_addr[5:2] == 4'h1);
  assign start   = strobe && sel_hit && (is_drw || is_bd);
  assign done    = (state == ACCESS) && apb.apb_pready && !ap.ap_abort;

  always_comb begin
    reg_rdata = '0;
    case (ap.ap_addr)
      6'h00:   reg_rdata = {24'h0, 1'b0, 1'b1, addr_inc, 1'b0, 3'b010};
      6'h01:   reg_rdata = tar;
      6'h3E:   reg_rdata = BASE;
      6'h3F:   reg_rdata = IDR;
      default: reg_rdata = '0;
    endcase
  end

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = ap.ap_abort ? IDLE : ACCESS;
      ACCESS:  if (ap.ap_abort || apb.apb_pready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      addr_inc <= 2'b00;
      tar      <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      pwrite   <= 1'b0;
      xfer_drw <= 1'b0;
    end else begin
      err <= done && apb.apb_pslverr;
      if (strobe && !start) begin
        if (sel_hit) begin
          if (ap.ap_wen) begin
            if (ap.ap_addr == 6'h00)
              addr_inc <= (ap.ap_wdata[5:4] == 2'b01) ? 2'b01 : 2'b00;
            if (ap.ap_addr == 6'h01)
              tar <= ap.ap_wdata;
          end
          if (ap.ap_ren) rdata <= reg_rdata;
        end else if (ap.ap_ren) begin
          rdata <= '0;
        end
      end
      if (start) begin
        paddr    <= is_drw ? {tar[31:2], 2'b00} : {tar[31:4], ap.ap_addr[1:0], 2'b00};
        pwrite   <= ap.ap_wen;
        pwdata   <= ap.ap_wdata;
        xfer_drw <= is_drw;
      end
      // Auto-increment walks only the word index inside the current 1 KB page.
      if (done) begin
        if (!pwrite) rdata <= apb.apb_prdata;
        if (!apb.apb_pslverr && xfer_drw && addr_inc == 2'b01)
          tar[9:2] <= tar[9:2] + 8'd1;
      end
    end
  end

  assign ap.ap_rdy      = (state == IDLE);
  assign ap.ap_err      = err;
  assign ap.ap_rdata    = rdata;
  assign apb.apb_psel    = (state != IDLE);
  assign apb.apb_penable = (state == ACCESS);
  assign apb.apb_paddr   = paddr;
  assign apb.apb_pwrite  = pwrite;
  assign apb.apb_pwdata  = pwdata;

endmodule

// File: tb/tb_opendap_mem_ap_apb.sv
// tb/tb_opendap_mem_ap_apb.sv - directed self-checking bench for opendap_mem_ap_apb
module tb_opendap_mem_ap_apb;
  localparam logic [7:0]  APSEL = 8'd0;
  localparam logic [31:0] IDR   = 32'h0477_0002;
  localparam logic [31:0] BASE  = 32'h0000_0003;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  logic swclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 swclk = ~swclk;

  opendap_ap_if  ap();
  opendap_apb_if apb();

  opendap_mem_ap_apb #(.APSEL(APSEL), .IDR(IDR), .BASE(BASE)) dut (
    .swclk(swclk),
    .rst_n(rst_n),
    .ap(ap),
    .apb(apb)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected per-cycle outputs, maintained by the transaction tasks.
  logic        chk_en = 1'b0;
  logic        exp_rdy = 1'b1, exp_psel = 1'b0, exp_pen = 1'b0, exp_err = 1'b0, exp_pwrite = 1'b0;
  logic [31:0] exp_rdata = '0, exp_paddr = '0, exp_pwdata = '0;

  // Architectural model of the AP registers.
  logic [31:0] m_tar = '0;
  logic        m_inc = 1'b0;

  int          rdy_low_cnt = 0;
  int          psel_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] last_paddr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_val(input logic [5:0] a);
    case (a)
      6'h00:   return 32'h42 | (m_inc ? 32'h10 : 32'h0);
      6'h01:   return m_tar;
      6'h3E:   return BASE;
      6'h3F:   return IDR;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge swclk) begin
    if (chk_en) begin
      chk("ap_rdy", 32'(ap.ap_rdy), 32'(exp_rdy));
      chk("apb_psel", 32'(apb.apb_psel), 32'(exp_psel));
      chk("apb_penable", 32'(apb.apb_penable), 32'(exp_pen));
      chk("ap_err", 32'(ap.ap_err), 32'(exp_err));
      chk("ap_rdata", ap.ap_rdata, exp_rdata);
      if (exp_psel) begin
        chk("apb_paddr", apb.apb_paddr, exp_paddr);
        chk("apb_pwrite", 32'(apb.apb_pwrite), 32'(exp_pwrite));
        chk("apb_pwdata", apb.apb_pwdata, exp_pwdata);
      end
    end
    if (!ap.ap_rdy) rdy_low_cnt++;
    if (ap.ap_err) err_cnt++;
    if (apb.apb_psel) begin
      psel_cnt++;
      last_paddr = apb.apb_paddr;
    end
  end

  task automatic set_idle_exp();
    exp_rdy = 1'b1; exp_psel = 1'b0; exp_pen = 1'b0;
  endtask

  // One DP access; abort_at: 0 none, 1 in SETUP, 2+k in the k-th ACCESS cycle.
  task automatic ap_access(input bit wr, input logic [7:0] sel, input logic [5:0] addr,
                           input logic [31:0] wdata, input int waits, input logic [31:0] resp,
                           input bit slverr, input int abort_at);
    bit xfer;
    bit drw;
    bit aborted;
    drw  = (addr == 6'h03);
    xfer = (sel == APSEL) && (drw || addr >= 6'h04 && addr <= 6'h07);
    ap.ap_sel = sel; ap.ap_addr = addr; ap.ap_wdata = wdata;
    ap.ap_wen = wr;  ap.ap_ren = !wr;
    if (xfer) begin
      exp_paddr  = drw ? (m_tar & 32'hFFFF_FFFC) : ((m_tar & 32'hFFFF_FFF0) + 32'(addr - 6'h04) * 4);
      exp_pwrite = wr;
      exp_pwdata = wdata;
    end
    @(posedge swclk); #1;
    ap.ap_wen = 1'b0; ap.ap_ren = 1'b0;
    if (!xfer) begin
      if (sel == APSEL) begin
        if (wr) begin
          if (addr == 6'h00) m_inc = (wdata[5:4] == 2'b01);
          else if (addr == 6'h01) m_tar = wdata;
        end else begin
          exp_rdata = reg_val(addr);
        end
      end else if (!wr) begin
        exp_rdata = 32'h0;
      end
      return;
    end
    exp_rdy = 1'b0; exp_psel = 1'b1; exp_pen = 1'b0;
    aborted = (abort_at == 1);
    ap.ap_abort = aborted;
    @(posedge swclk); #1;
    ap.ap_abort = 1'b0;
    if (!aborted) begin
      for (int k = 0; k <= waits; k++) begin
        exp_pen = 1'b1;
        apb.apb_pready  = (k == waits);
        apb.apb_prdata  = (k == waits) ? resp : JUNK;
        apb.apb_pslverr = (k == waits) && slverr;
        ap.ap_abort     = (abort_at == k + 2);
        @(posedge swclk); #1;
        apb.apb_pready = 1'b0; apb.apb_prdata = JUNK; apb.apb_pslverr = 1'b0;
        if (ap.ap_abort) begin
          ap.ap_abort = 1'b0;
          aborted = 1'b1;
          break;
        end
      end
    end
    set_idle_exp();
    if (!aborted) begin
      if (!wr) exp_rdata = resp;
      if (!slverr && drw && m_inc)
        m_tar = (m_tar & ~32'h3FC) | ((m_tar + 32'd4) & 32'h3FC);
      exp_err = slverr;
      if (slverr) begin
        @(posedge swclk); #1;
        exp_err = 1'b0;
      end
    end
  endtask

  task automatic wr_reg(input logic [5:0] a, input logic [31:0] d);
    ap_access(1'b1, APSEL, a, d, 0, 32'h0, 1'b0, 0);
  endtask

  task automatic rd_reg(input logic [5:0] a);
    ap_access(1'b0, APSEL, a, 32'h0, 0, 32'h0, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    ap.ap_sel = '0; ap.ap_addr = '0; ap.ap_wdata = '0;
    ap.ap_wen = 1'b0; ap.ap_ren = 1'b0; ap.ap_abort = 1'b0;
    apb.apb_prdata = JUNK; apb.apb_pready = 1'b0; apb.apb_pslverr = 1'b0;
    #12;
    chk("rst_rdy", 32'(ap.ap_rdy), 32'd1);
    chk("rst_err", 32'(ap.ap_err), 32'd0);
    chk("rst_rdata", ap.ap_rdata, 32'h0);
    chk("rst_psel", 32'(apb.apb_psel), 32'd0);
    chk("rst_penable", 32'(apb.apb_penable), 32'd0);
    chk("rst_pwrite", 32'(apb.apb_pwrite), 32'd0);
    chk("rst_paddr", apb.apb_paddr, 32'h0);
    chk("rst_pwdata", apb.apb_pwdata, 32'h0);
    @(negedge swclk); rst_n = 1'b1;
    @(posedge swclk); #1; chk_en = 1'b1;

    // Register-only accesses
    psel_cnt = 0;
    wr_reg(6'h01, 32'h2000_0010);
    wr_reg(6'h00, 32'h0000_0010);
    rd_reg(6'h00); chk("csw_read", ap.ap_rdata, 32'h52);
    rd_reg(6'h01); chk("tar_read", ap.ap_rdata, 32'h2000_0010);
    chk("reg_no_apb", psel_cnt, 0);

    // Two auto-incrementing DRW writes
    rdy_low_cnt = 0;
    ap_access(1'b1, APSEL, 6'h03, 32'hA5A5_0001, 0, 32'h0, 1'b0, 0);
    chk("drw_wr1_busy", rdy_low_cnt, 2);
    chk("drw_wr1_addr", last_paddr, 32'h2000_0010);
    rdy_low_cnt = 0;
    ap_access(1'b1, APSEL, 6'h03, 32'hA5A5_0002, 0, 32'h0, 1'b0, 0);
    chk("drw_wr2_busy", rdy_low_cnt, 2);
    chk("drw_wr2_addr", last_paddr, 32'h2000_0014);
    rd_reg(6'h01); chk("tar_after_wr", ap.ap_rdata, 32'h2000_0018);

    // 1 KB wrap with three wait states
    wr_reg(6'h01, 32'h2000_03FC);
    rdy_low_cnt = 0;
    ap_access(1'b0, APSEL, 6'h03, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 0);
    chk("wrap_busy", rdy_low_cnt, 5);
    chk("wrap_rdata", ap.ap_rdata, 32'hCAFE_F00D);
    rd_reg(6'h01); chk("wrap_tar", ap.ap_rdata, 32'h2000_0000);

    // Slave error
    err_cnt = 0;
    ap_access(1'b0, APSEL, 6'h03, 32'h0, 1, 32'h1111_2222, 1'b1, 0);
    chk("slverr_pulse", err_cnt, 1);
    rd_reg(6'h01); chk("slverr_tar", ap.ap_rdata, 32'h2000_0000);

    // Abort during ACCESS and during SETUP
    err_cnt = 0;
    ap_access(1'b0, APSEL, 6'h03, 32'h0, 10, 32'h5555_5555, 1'b0, 3);
    chk("abort_rdata_kept", ap.ap_rdata, 32'h2000_0000);
    ap_access(1'b1, APSEL, 6'h03, 32'h77, 0, 32'h0, 1'b0, 1);
    chk("abort_no_err", err_cnt, 0);
    rd_reg(6'h01); chk("abort_tar", ap.ap_rdata, 32'h2000_0000);

    // Identification and AP select
    rd_reg(6'h3F); chk("idr_read", ap.ap_rdata, 32'h0477_0002);
    rd_reg(6'h3E); chk("base_read", ap.ap_rdata, 32'h0000_0003);
    ap_access(1'b0, 8'(APSEL + 8'd1), 6'h3F, 32'h0, 0, 32'h0, 1'b0, 0);
    chk("idr_other_ap", ap.ap_rdata, 32'h0);
    psel_cnt = 0;
    ap_access(1'b1, 8'(APSEL + 8'd1), 6'h03, 32'h1234, 0, 32'h0, 1'b0, 0);
    chk("other_ap_no_apb", psel_cnt, 0);

    // Unsupported AddrInc value, then banked accesses
    wr_reg(6'h00, 32'h0000_0030);
    rd_reg(6'h00); chk("csw_inc_reserved", ap.ap_rdata, 32'h42);
    wr_reg(6'h01, 32'h1234_5678);
    ap_access(1'b0, APSEL, 6'h05, 32'h0, 0, 32'hBD01_BD01, 1'b0, 0);
    chk("bd1_addr", last_paddr, 32'h1234_5674);
    chk("bd1_rdata", ap.ap_rdata, 32'hBD01_BD01);
    ap_access(1'b1, APSEL, 6'h07, 32'h0BD3_0BD3, 1, 32'h0, 1'b0, 0);
    chk("bd3_addr", last_paddr, 32'h1234_567C);

    // Strobe in the same cycle as abort is ignored
    ap.ap_sel = APSEL; ap.ap_addr = 6'h01; ap.ap_wdata = 32'hFFFF_FFFF;
    ap.ap_wen = 1'b1; ap.ap_abort = 1'b1;
    @(posedge swclk); #1;
    ap.ap_wen = 1'b0; ap.ap_abort = 1'b0;
    rd_reg(6'h01); chk("abort_strobe_ignored", ap.ap_rdata, 32'h1234_5678);

    // Asynchronous reset in the middle of a transfer
    chk_en = 1'b0;
    ap.ap_sel = APSEL; ap.ap_addr = 6'h03; ap.ap_wdata = 32'h9999_9999; ap.ap_wen = 1'b1;
    @(posedge swclk); #1; ap.ap_wen = 1'b0;
    @(posedge swclk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_psel", 32'(apb.apb_psel), 32'd0);
    chk("arst_penable", 32'(apb.apb_penable), 32'd0);
    chk("arst_rdy", 32'(ap.ap_rdy), 32'd1);
    chk("arst_paddr", apb.apb_paddr, 32'h0);
    chk("arst_pwdata", apb.apb_pwdata, 32'h0);
    chk("arst_rdata", ap.ap_rdata, 32'h0);
    m_tar = '0; m_inc = 1'b0; exp_rdata = '0; exp_err = 1'b0;
    set_idle_exp();
    @(negedge swclk); rst_n = 1'b1;
    @(posedge swclk); #1; chk_en = 1'b1;
    rd_reg(6'h01); chk("arst_tar", ap.ap_rdata, 32'h0);

    @(posedge swclk); #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/opendap_mem_ap_apb.md
# opendap_mem_ap_apb

Single-AP MEM-AP that sits directly downstream of the SW-DP's AP interface and turns AP register accesses into APB master transfers. It implements CSW, TAR, DRW, BD0-3, CFG, BASE and IDR for 32-bit accesses only, with optional single-word auto-increment. It paces the DP through `ap_rdy`/`ap_err` and honours DAPABORT.

## Interface
Parameters:
- `APSEL`, 8'd0: AP number this block answers to.
- `IDR`, 32'h0477_0002: value returned for the IDR register.
- `BASE`, 32'h0000_0003: value returned for the BASE register (ROM-table pointer, format bit set, present).

Ports:
- `swclk` in 1: single clock, shared with the DP and the APB.
- `rst_n` in 1: asynchronous, active-low reset.
- `ap_sel` in 8: AP select; valid only when `ap_wen` or `ap_ren` is high.
- `ap_addr` in 6: {APBANKSEL, A[3:2]}; valid only when `ap_wen` or `ap_ren` is high.
- `ap_wdata` in 32: write data; valid only when `ap_wen` is high.
- `ap_wen`, `ap_ren`, `ap_abort` in 1: write strobe, read strobe, and DAPABORT.
- `ap_rdata` out 32: read data.
- `ap_rdy` out 1: AP idle, ready for the next access.
- `ap_err` out 1: transfer error.
- `apb_paddr` out 32, `apb_psel` out 1, `apb_penable` out 1, `apb_pwrite` out 1, `apb_pwdata` out 32: APB master request.
- `apb_prdata` in 32, `apb_pready` in 1, `apb_pslverr` in 1: APB completer response.

## Operation
- Register byte offset is `ap_addr*4`:
  - 0x00 CSW
  - 0x04 TAR
  - 0x0C DRW
  - 0x10/14/18/1C BD0-3
  - 0xF4 CFG, reads 0
  - 0xF8 BASE
  - 0xFC IDR
  - All other offsets: RAZ/WI.
- CSW fields:
  - [2:0] Size: RO 3'b010.
  - [5:4] AddrInc: RW. Only 2'b00 (off) and 2'b01 (single) are stored; any other written value stores 2'b00.
  - [6] DeviceEn: RO 1.
  - [7] TrInProg: RO, reads 0 when readable.
  - All other bits RAZ/WI.
- TAR: 32-bit RW; bits [1:0] are stored but forced to 0 on `apb_paddr`.
- If `ap_sel != APSEL`, the access is ignored: reads return 0, writes have no effect, no APB activity, `ap_rdy` stays 1, `ap_err` stays 0.
- CSW, TAR, CFG, BASE, IDR and RAZ accesses complete immediately. On a read, `ap_rdata` is loaded at the strobe edge.
- DRW/BD accesses start an APB transfer. At the strobe edge, capture:
  - `apb_paddr` = {TAR[31:2], 2'b00} for DRW, or {TAR[31:4], ap_addr[1:0], 2'b00} for BD.
  - `apb_pwrite` = `ap_wen`.
  - `apb_pwdata` = `ap_wdata`.
- FSM states and transitions:
  - IDLE -> SETUP on a DRW/BD strobe.
  - SETUP -> ACCESS unconditionally.
  - ACCESS holds until `apb_pready`, then goes to IDLE.
- Outputs per state:
  - IDLE: `apb_psel`=0, `apb_penable`=0.
  - SETUP: `apb_psel`=1, `apb_penable`=0.
  - ACCESS: `apb_psel`=1, `apb_penable`=1.
- `ap_rdy` = (state==IDLE), combinational from the state register.
- On ACCESS completion:
  - On a read, `ap_rdata` <= `apb_prdata`.
  - `ap_err` <= `apb_pslverr`.
  - If `apb_pslverr`=0 and AddrInc==01, TAR[9:2] <= TAR[9:2]+1, wrapping modulo 1 KB. TAR[31:10] and TAR[1:0] are unchanged.
  - If `apb_pslverr`=1, TAR is unchanged.
- `ap_err` is a one-cycle pulse: it is high only on the first IDLE cycle after a failed transfer and cleared on the next edge.
- `ap_abort` in SETUP or ACCESS forces IDLE at the next edge:
  - `apb_psel` and `apb_penable` drop.
  - `ap_err`=0.
  - TAR is unchanged.
  - `ap_rdata` is unchanged.
  - This is an accepted APB deviation, used only for abort.
- `ap_abort` in IDLE has no effect.
- A strobe in the same cycle as abort is ignored.
- Strobes while not IDLE are ignored; the DP never issues them.

## Timing
- Reset values:
  - `ap_rdy`=1; `ap_err`=0; `ap_rdata`=0.
  - `apb_psel`=0; `apb_penable`=0; `apb_pwrite`=0; `apb_paddr`=0; `apb_pwdata`=0.
  - CSW.AddrInc=00; TAR=0; FSM=IDLE.
- Register access, strobe at cycle N: `ap_rdy`=1 throughout, and `ap_rdata` is valid from N+1.
- DRW/BD access, strobe at cycle N:
  - N+1: SETUP, `ap_rdy`=0.
  - N+2: first ACCESS cycle.
  - With `apb_pready`=1 at N+2, the FSM is IDLE at N+3 with data valid and `ap_err` valid at N+3 only. Each wait state adds one cycle.
- `ap_rdata` holds its value until the next read completes.
- A reset assertion mid-transfer immediately returns every output to its reset value, asynchronously.
- The DRW auto-increment wrap boundary is TAR[9:2]=0xFF -> 0x00.

## Test plan
- Write TAR=0x2000_0010 and CSW=0x10, then read CSW and TAR -> CSW reads 0x52 (AddrInc=01, DeviceEn=1, Size=010), TAR reads 0x2000_0010; no APB activity.
- Two DRW writes 0xA5A5_0001 and 0xA5A5_0002 with `apb_pready`=1 -> APB writes to 0x2000_0010 and 0x2000_0014; `ap_rdy` low for exactly 2 cycles each; TAR ends at 0x2000_0018.
- TAR=0x2000_03FC, AddrInc=01, DRW read with `apb_prdata`=0xCAFEF00D and 3 wait states -> `ap_rdy` low for 5 cycles, `ap_rdata`=0xCAFEF00D, TAR=0x2000_0000.
- DRW read with `apb_pslverr`=1 -> `ap_err` high for exactly one cycle (the first `ap_rdy`=1 cycle), TAR unchanged.
- Abort during ACCESS with `apb_pready` held at 0 -> next cycle IDLE, `apb_psel`=0, `ap_rdy`=1, `ap_err`=0, TAR unchanged.
- Read IDR with `ap_addr`=0x3F and `ap_sel`=APSEL -> 0x0477_0002; the same read with `ap_sel`=APSEL+1 -> 0, and a DRW write with `ap_sel`=APSEL+1 produces no APB activity.
